// File: rtl/permute_result_combiner.sv
// N-lane result combiner: shared grab of all lanes, registered pairwise adder tree,
// credit-managed output queue. Optional lane-skew detector under COMBINER_SKEW_CHECK_EN.
module permute_result_combiner #(
  parameter int unsigned N_LANES          = 4,
  parameter int unsigned LANE_SUM_WIDTH   = 48,
  parameter int unsigned LANE_COUNT_WIDTH = 13,
  parameter int unsigned OUT_DEPTH        = 4,
  parameter int unsigned MAX_SKEW         = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_LANES-1:0]                            laneResultsAvailable,
  input  logic [N_LANES*LANE_SUM_WIDTH-1:0]             laneSums,
  input  logic [N_LANES*LANE_COUNT_WIDTH-1:0]           laneCounts,
  output logic                                          grabResults,
  output logic                                          resultValid,
  input  logic                                          resultReady,
  output logic [LANE_SUM_WIDTH+$clog2(N_LANES)-1:0]     pcoeffSum,
  output logic [LANE_COUNT_WIDTH+$clog2(N_LANES)-1:0]   pcoeffCount,
  output logic                                          skewError
);

  localparam int unsigned LOG2_LANES = $clog2(N_LANES);
  localparam int unsigned SUM_W      = LANE_SUM_WIDTH + LOG2_LANES;
  localparam int unsigned CNT_W      = LANE_COUNT_WIDTH + LOG2_LANES;
  localparam int unsigned CRD_W      = $clog2(OUT_DEPTH + 1);

  // A misconfigured instance never grabs, so it cannot corrupt the lane array.
  localparam bit CFG_OK = (N_LANES >= 1) && (N_LANES <= 16) &&
                          ((N_LANES & (N_LANES - 1)) == 0) &&
                          (OUT_DEPTH >= 1) && (OUT_DEPTH <= 16) && (MAX_SKEW >= 1);

  logic [CRD_W-1:0] r_credits;
  logic             w_grab;
  logic             w_pop;

  logic [SUM_W-1:0] r_tsum [LOG2_LANES+1][N_LANES];
  logic [CNT_W-1:0] r_tcnt [LOG2_LANES+1][N_LANES];
  logic [LOG2_LANES:0] r_tvld;

  logic             w_exit_vld;
  logic [SUM_W-1:0] w_exit_sum;
  logic [CNT_W-1:0] w_exit_cnt;

  logic [SUM_W-1:0] r_qsum [OUT_DEPTH];
  logic [CNT_W-1:0] r_qcnt [OUT_DEPTH];
  logic [CRD_W-1:0] r_qlen;
  logic             r_valid;
  logic [CRD_W-1:0] w_qlen_after;
  logic [CRD_W-1:0] w_qlen_next;

  always_comb begin
    w_grab = !rst && (&laneResultsAvailable) && (r_credits != '0) && CFG_OK;
    w_pop  = r_valid && resultReady;
  end

  assign grabResults = w_grab;

  // Credits = queue slots not yet claimed by a grab still in the tree or an unpopped entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= CRD_W'(OUT_DEPTH);
    end else begin
      unique case ({w_grab, w_pop})
        2'b10:   r_credits <= r_credits - CRD_W'(1);
        2'b01:   r_credits <= r_credits + CRD_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Level 0 captures the lanes; level k holds N_LANES>>k partial sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tvld <= '0;
      for (int k = 0; k <= int'(LOG2_LANES); k++) begin
        for (int j = 0; j < int'(N_LANES); j++) begin
          r_tsum[k][j] <= '0;
          r_tcnt[k][j] <= '0;
        end
      end
    end else begin
      r_tvld[0] <= w_grab;
      if (w_grab) begin
        for (int i = 0; i < int'(N_LANES); i++) begin
          r_tsum[0][i] <= SUM_W'(laneSums[i*LANE_SUM_WIDTH +: LANE_SUM_WIDTH]);
          r_tcnt[0][i] <= CNT_W'(laneCounts[i*LANE_COUNT_WIDTH +: LANE_COUNT_WIDTH]);
        end
      end
      for (int k = 1; k <= int'(LOG2_LANES); k++) begin
        r_tvld[k] <= r_tvld[k-1];
        for (int j = 0; j < int'(N_LANES >> k); j++) begin
          r_tsum[k][j] <= r_tsum[k-1][2*j] + r_tsum[k-1][2*j+1];
          r_tcnt[k][j] <= r_tcnt[k-1][2*j] + r_tcnt[k-1][2*j+1];
        end
        for (int j = int'(N_LANES >> k); j < int'(N_LANES); j++) begin
          r_tsum[k][j] <= '0;
          r_tcnt[k][j] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_exit_vld = r_tvld[LOG2_LANES];
    w_exit_sum = r_tsum[LOG2_LANES][0];
    w_exit_cnt = r_tcnt[LOG2_LANES][0];
  end

  always_comb begin
    w_qlen_after = r_qlen - CRD_W'(w_pop);
    w_qlen_next  = w_qlen_after + CRD_W'(w_exit_vld);
  end

  // Shift queue with entry 0 as the registered head; a lone popped head is left in
  // place so the outputs keep the last popped value while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qlen  <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        r_qsum[i] <= '0;
        r_qcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(OUT_DEPTH) - 1; i++) begin
        if (w_pop && (CRD_W'(i + 1) < r_qlen)) begin
          r_qsum[i] <= r_qsum[i+1];
          r_qcnt[i] <= r_qcnt[i+1];
        end
      end
      if (w_exit_vld) begin
        for (int i = 0; i < int'(OUT_DEPTH); i++) begin
          if (CRD_W'(i) == w_qlen_after) begin
            r_qsum[i] <= w_exit_sum;
            r_qcnt[i] <= w_exit_cnt;
          end
        end
      end
      r_qlen  <= w_qlen_next;
      r_valid <= (w_qlen_next != '0);
    end
  end

  assign resultValid = r_valid;
  assign pcoeffSum   = r_qsum[0];
  assign pcoeffCount = r_qcnt[0];

`ifdef COMBINER_SKEW_CHECK_EN
  localparam int unsigned SKW_W = $clog2(MAX_SKEW + 1);

  logic [SKW_W-1:0] r_skew_cnt;
  logic             r_skew_err;
  logic             w_partial;

  always_comb begin
    w_partial = (|laneResultsAvailable) && !(&laneResultsAvailable);
  end

  // Counts consecutive cycles with only some lanes ready; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skew_cnt <= '0;
      r_skew_err <= 1'b0;
    end else if (w_grab || !w_partial) begin
      r_skew_cnt <= '0;
    end else if (r_skew_cnt != SKW_W'(MAX_SKEW)) begin
      r_skew_cnt <= r_skew_cnt + SKW_W'(1);
      if ((r_skew_cnt + SKW_W'(1)) == SKW_W'(MAX_SKEW)) begin
        r_skew_err <= 1'b1;
      end
    end
  end

  assign skewError = r_skew_err;
`else
  assign skewError = 1'b0;
`endif

endmodule
